rr_arb8_ctrl: RTL and testbench
===============================

Name: rr_arb8_ctrl

Overview:
- Round-robin arbiter and hold controller that shares one resource among 8 requesters.
- Produces a registered one-hot grant and its 3-bit encoded index for downstream mux select and address tagging.
- Limits grant tenure with an optional hold timeout.
- Sits in front of the shared datapath as the sequencing block that feeds the 8:3 encoding stage with legal one-hot inputs only.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, encoded index width; equals log2(N_REQ).
- MAX_HOLD, 16, maximum grant tenure in cycles; 0 disables the timeout.
- CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  request vector; bit k is requester k, level-sensitive.
- done  in  1  current grantee finished; sampled only in GRANT.
- gnt  out  8  registered one-hot grant; all-zero when idle.
- gnt_idx  out  3  encoded index of the gnt bit; holds last value when idle.
- gnt_vld  out  1  high while gnt is non-zero.
- timeout  out  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=7, hold_cnt=0. Because ptr=7, the first search priority starts at requester 0.
- All outputs come straight from flops. There is no combinational path from req or done to any output.
- IDLE state:
  - If req is non-zero, select the first set bit scanning ptr+1, ptr+2, … with wrap mod 8.
  - At that edge: gnt=onehot(sel), gnt_idx=sel, gnt_vld=1, hold_cnt=0, state goes to GRANT.
  - Latency: req seen at edge k gives gnt visible after edge k (1 cycle).
  - If req is zero, remain in IDLE with outputs unchanged (gnt=0).
- GRANT state, release conditions evaluated each edge, in priority order:
  - (a) done=1.
  - (b) req[gnt_idx]=0, i.e. the requester withdrew.
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1, which is a timeout.
- On release:
  - gnt=0, gnt_vld=0, ptr=gnt_idx, state goes to IDLE. gnt_idx keeps its value.
  - timeout=1 for one cycle only when (c) is the sole cause. done or withdraw in the same cycle as (c) suppresses timeout.
- Without a release, hold_cnt increments and saturates; the grant is unchanged.
- Inter-grant gap: at least one cycle with gnt=0 between any two grants, including a re-grant to the same requester. This gives the downstream datapath a clean handoff.
- Fairness:
  - The requester just released has lowest priority in the next search.
  - With all 8 requesting continuously, grants rotate 0,1,…,7,0.
  - Worst-case wait for any requester is 7×(MAX_HOLD+1) cycles.
- Requests that change during GRANT do not affect the current grant, except req[gnt_idx] per (b).
- A req pulse shorter than one cycle between edges is not captured; requesters must hold req until granted.
- Invariant: gnt is zero or one-hot at all times, and gnt_idx==encode(gnt) whenever gnt_vld=1.
- Reset asserted mid-grant: outputs clear immediately and asynchronously, and ptr returns to 7.

Decomposition:
- Shared package arb_pkg:
  - Constants N_REQ=8 and IDX_W=3.
  - Enum state_t {IDLE, GRANT}.
  - Function rr_pick(req, ptr), returning the index to grant.
- One sub-module, onehot8_to_idx: purely combinational 8:3 one-hot-to-binary encoder, output 0 on a non-one-hot input. It is used to derive gnt_idx from the next-gnt vector, so index and one-hot come from one source.

Test Plan:
- Reset release, req=8'b0000_0001, done after 3 cycles -> gnt=01 and gnt_idx=0 one cycle after req. gnt held 3 cycles, then gnt=0 for one cycle. timeout stays 0.
- req=8'hFF held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,…,7,0 with exactly one idle cycle between grants.
- Only req[5] set, MAX_HOLD=16, done never asserted -> gnt=20h for 16 cycles, then timeout pulses once and gnt=0. The next grant goes back to 5 after the one-cycle gap.
- Grant to 2 active, req[2] dropped while req[6] and req[1] stay high -> release on the next edge with no timeout, then grant goes to 6 (the search starts at 3).
- done and the timeout condition in the same cycle -> release occurs and timeout stays 0.
- rst_n pulsed low mid-grant to 4 with req=8'h1F -> gnt=0 immediately. After release, the first grant goes to 0 (ptr reset to 7).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and the round-robin search function for the 8-way arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request strictly after ptr, wrapping; the slot at ptr is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/onehot8_to_idx.sv
// Combinational 8:3 one-hot to binary encoder; any non-one-hot input maps to 0.
module onehot8_to_idx
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx = '0;
        case (onehot)
            8'b0000_0001: idx = 3'd0;
            8'b0000_0010: idx = 3'd1;
            8'b0000_0100: idx = 3'd2;
            8'b0000_1000: idx = 3'd3;
            8'b0001_0000: idx = 3'd4;
            8'b0010_0000: idx = 3'd5;
            8'b0100_0000: idx = 3'd6;
            8'b1000_0000: idx = 3'd7;
            default:      idx = 3'd0;
        endcase
    end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded index
// and an optional hold timeout.
//
// state | meaning
// IDLE  | no grant outstanding; searching req from ptr+1 each cycle
// GRANT | one requester owns the resource until done, withdraw or timeout
module rr_arb8_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam bit               HOLD_EN   = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t           state, state_d;
    logic [IDX_W-1:0] ptr, ptr_d;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
    logic [N_REQ-1:0] gnt_d;
    logic [IDX_W-1:0] gnt_idx_d;
    logic [IDX_W-1:0] enc_idx;
    logic             gnt_vld_d;
    logic             timeout_d;
    logic             rel_done;
    logic             rel_wd;
    logic             rel_to;
    logic [IDX_W-1:0] sel;

    // Index is derived from the same next-grant vector that is registered into gnt.
    onehot8_to_idx u_enc (
        .onehot (gnt_d),
        .idx    (enc_idx)
    );

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        hold_cnt_d = hold_cnt;
        gnt_d      = gnt;
        gnt_vld_d  = gnt_vld;
        timeout_d  = 1'b0;
        sel        = rr_pick(req, ptr);
        rel_done   = 1'b0;
        rel_wd     = 1'b0;
        rel_to     = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d      = N_REQ'(1) << sel;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                rel_done = done;
                rel_wd   = ~req[gnt_idx];
                rel_to   = HOLD_EN && (hold_cnt == HOLD_LAST);
                if (rel_done || rel_wd || rel_to) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx;
                    state_d   = IDLE;
                    // Timeout is flagged only when nothing else explains the release.
                    timeout_d = rel_to && !rel_done && !rel_wd;
                end else if (hold_cnt != '1) begin
                    hold_cnt_d = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        gnt_idx_d = gnt_vld_d ? enc_idx : gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '1;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_cnt_d;
            gnt      <= gnt_d;
            gnt_idx  <= gnt_idx_d;
            gnt_vld  <= gnt_vld_d;
            timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed vector bench for rr_arb8_ctrl: a stimulus table plus hand-written
// timeout and reset sequences.
module tb_rr_arb8_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    rr_arb8_ctrl #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
        n_vec++;
        if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev || timeout !== et) begin
            n_miss++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, required gnt=%h idx=%0d vld=%b to=%b",
                     name, gnt, gnt_idx, gnt_vld, timeout, eg, ei, ev, et);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic [7:0] eg,
                        input logic [2:0] ei, input logic ev, input logic et, input string name);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        chk(name, eg, ei, ev, et);
    endtask

    function automatic vec_t mk(input logic [7:0] r, input logic d, input logic [7:0] g,
                                input logic [2:0] i, input logic v, input logic t);
        vec_t x;
        x.req = r; x.done = d; x.gnt = g; x.idx = i; x.vld = v; x.to = t;
        return x;
    endfunction

    initial begin
        logic [7:0] one;
        int         k;
        one = 8'h01;

        // Single requester 0, held three cycles, then done.
        tbl.push_back(mk(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
        // All requesting; ptr is 0 now, so rotation starts at 1 and wraps through 0.
        for (int j = 0; j < 9; j++) begin
            k = (1 + j) % 8;
            tbl.push_back(mk(8'hFF, 1'b0, one << k, 3'(k), 1'b1, 1'b0));
            tbl.push_back(mk(8'hFF, 1'b1, 8'h00,    3'(k), 1'b0, 1'b0));
        end
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0));
        // Grant to 2, requester 2 withdraws, search resumes at 3 and finds 6.
        tbl.push_back(mk(8'h46, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0));
        tbl.push_back(mk(8'h42, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(8'h42, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0));
        tbl.push_back(mk(8'h42, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0));

        req   = 8'h00;
        done  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].done, tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to,
                 $sformatf("tbl[%0d]", i));
        end

        // Requester 5 alone, never done: 16 cycles of grant, then a single timeout pulse.
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "to_grant");
        for (int i = 0; i < 15; i++)
            step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, $sformatf("to_hold%0d", i));
        step(8'h20, 1'b0, 8'h00, 3'd5, 1'b0, 1'b1, "to_fire");
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "to_regrant");
        step(8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, "to_done");

        // done coincides with the timeout condition.
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "dt_grant");
        for (int i = 0; i < 15; i++)
            step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, $sformatf("dt_hold%0d", i));
        step(8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, "done_and_to");
        step(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, "dt_idle");

        // Withdraw coincides with the timeout condition.
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "wt_grant");
        for (int i = 0; i < 15; i++)
            step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, $sformatf("wt_hold%0d", i));
        step(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, "wd_and_to");
        step(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, "wt_idle");

        // Set ptr to 3, then grant 4 and hit it with an asynchronous reset.
        step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "g3");
        step(8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "g3_rel");
        step(8'h1F, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "g4");
        step(8'h1F, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "g4_hold");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_grant0", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
